axi_read_arbiter: RTL and testbench

Shares one AXI3 read-address/read-data channel pair between the ICache (ibus, port index 1) and DCache (dbus, port index 0) refill engines. Write channels are not routed through this block because only the DCache issues writes. One read burst is in flight at a time. DCache has default priority, and an ICache starvation counter forces ICache service. Sits between the cache controllers and the external m_axi read interface.

---
 rtl/axi_read_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Two-port AXI3 read arbiter: ICache (port 1) and DCache (port 0) share one AR/R channel pair.
// One burst in flight; DCache has priority unless the ICache has lost MAX_WAIT arbitrations.
module axi_read_arbiter #(
   parameter int unsigned MAX_WAIT = 8,
   parameter int unsigned ID_W     = 4
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [2*ID_W-1:0] s_arid,
   input  logic [63:0]       s_araddr,
   input  logic [15:0]       s_arlen,
   input  logic [5:0]        s_arsize,
   input  logic [3:0]        s_arburst,
   input  logic [1:0]        s_arvalid,
   output logic [1:0]        s_arready,
   output logic [ID_W-1:0]   s_rid,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rlast,
   output logic [1:0]        s_rvalid,
   input  logic [1:0]        s_rready,
   output logic [ID_W-1:0]   m_axi_arid,
   output logic [31:0]       m_axi_araddr,
   output logic [3:0]        m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   output logic [1:0]        m_axi_arburst,
   output logic [1:0]        m_axi_arlock,
   output logic [3:0]        m_axi_arcache,
   output logic [2:0]        m_axi_arprot,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [ID_W-1:0]   m_axi_rid,
   input  logic [31:0]       m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready,
   output logic              busy,
   output logic              owner,
   output logic              protocol_err
);

   localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t          r_state;
   logic [7:0]      r_starve;
   logic [3:0]      r_beats;
   logic            r_owner;
   logic            r_perr;
   logic [1:0]      r_arready;
   logic            r_arvalid;
   logic [ID_W-1:0] r_arid;
   logic [31:0]     r_araddr;
   logic [3:0]      r_arlen;
   logic [2:0]      r_arsize;
   logic [1:0]      r_arburst;

   logic            w_win;
   logic            w_grant;
   logic            w_beat;
   logic [ID_W-1:0] w_sel_id;
   logic [31:0]     w_sel_addr;
   logic [7:0]      w_sel_len;
   logic [2:0]      w_sel_size;
   logic [1:0]      w_sel_burst;

   assign w_win   = s_arvalid[1] & (~s_arvalid[0] | (r_starve >= LP_MAX_WAIT));
   assign w_grant = (r_state == IDLE) & (|s_arvalid);
   assign w_beat  = (r_state == DATA) & m_axi_rvalid & m_axi_rready;

   assign w_sel_id    = w_win ? s_arid[2*ID_W-1:ID_W] : s_arid[ID_W-1:0];
   assign w_sel_addr  = w_win ? s_araddr[63:32]       : s_araddr[31:0];
   assign w_sel_len   = w_win ? s_arlen[15:8]         : s_arlen[7:0];
   assign w_sel_size  = w_win ? s_arsize[5:3]         : s_arsize[2:0];
   assign w_sel_burst = w_win ? s_arburst[3:2]        : s_arburst[1:0];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= IDLE;
         r_starve  <= '0;
         r_beats   <= '0;
         r_owner   <= 1'b0;
         r_perr    <= 1'b0;
         r_arready <= '0;
         r_arvalid <= 1'b0;
         r_arid    <= '0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arburst <= '0;
      end else begin
         r_arready <= '0;
         case (r_state)
            IDLE: begin
               if (|s_arvalid) begin
                  r_arready <= w_win ? 2'b10 : 2'b01;
                  r_owner   <= w_win;
                  r_arid    <= w_sel_id;
                  r_araddr  <= w_sel_addr;
                  r_arlen   <= w_sel_len[3:0];
                  r_arsize  <= w_sel_size;
                  r_arburst <= w_sel_burst;
                  r_beats   <= w_sel_len[3:0];
                  r_arvalid <= 1'b1;
                  r_state   <= ADDR;
                  if (|w_sel_len[7:4]) r_perr <= 1'b1;
               end
            end
            ADDR: begin
               if (m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_state   <= DATA;
               end
            end
            DATA: begin
               if (w_beat) begin
                  if (m_axi_rlast) begin
                     r_state <= IDLE;
                     if (r_beats != '0) r_perr <= 1'b1;
                  end else if (r_beats == '0) begin
                     r_perr <= 1'b1;
                  end else begin
                     r_beats <= r_beats - 4'd1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase

         // Counts lost arbitrations only, so a long dbus burst does not by itself force an ibus win.
         if (!s_arvalid[1] || (w_grant && w_win))
            r_starve <= '0;
         else if (w_grant && r_starve != 8'hFF)
            r_starve <= r_starve + 8'd1;
      end
   end

   assign s_arready     = r_arready;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_arid    = r_arid;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = r_arlen;
   assign m_axi_arsize  = r_arsize;
   assign m_axi_arburst = r_arburst;
   assign m_axi_arlock  = '0;
   assign m_axi_arcache = '0;
   assign m_axi_arprot  = '0;

   assign s_rid   = m_axi_rid;
   assign s_rdata = m_axi_rdata;
   assign s_rresp = m_axi_rresp;
   assign s_rlast = m_axi_rlast;

   assign s_rvalid     = (r_state != DATA) ? 2'b00 :
                         (r_owner ? {m_axi_rvalid, 1'b0} : {1'b0, m_axi_rvalid});
   assign m_axi_rready = (r_state == DATA) & s_rready[r_owner];

   assign busy         = (r_state != IDLE);
   assign owner        = r_owner;
   assign protocol_err = r_perr;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: TB-side masters and AXI slave, with a transaction-level
// reference model predicting grants, handshakes, routing and error flags each cycle.
module tb_axi_read_arbiter;

   localparam int ID_W     = 4;
   localparam int MAX_WAIT = 2;
   localparam int AW       = ID_W + 41;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [2*ID_W-1:0] s_arid;
   logic [63:0]       s_araddr;
   logic [15:0]       s_arlen;
   logic [5:0]        s_arsize;
   logic [3:0]        s_arburst;
   logic [1:0]        s_arvalid, s_arready;
   logic [ID_W-1:0]   s_rid;
   logic [31:0]       s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rlast;
   logic [1:0]        s_rvalid, s_rready;
   logic [ID_W-1:0]   m_axi_arid, m_axi_rid;
   logic [31:0]       m_axi_araddr, m_axi_rdata;
   logic [3:0]        m_axi_arlen, m_axi_arcache;
   logic [2:0]        m_axi_arsize, m_axi_arprot;
   logic [1:0]        m_axi_arburst, m_axi_arlock, m_axi_rresp;
   logic              m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic              busy, owner, protocol_err;

   axi_read_arbiter #(.MAX_WAIT(MAX_WAIT), .ID_W(ID_W)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready), .busy(busy), .owner(owner), .protocol_err(protocol_err)
   );

   always #5 aclk = ~aclk;

   int vectors = 0;
   int miscompares = 0;

   // requesters
   logic [1:0]      req, auto_req;
   bit              rand_req, rand_rready;
   int              stall_cnt;
   logic [ID_W-1:0] p_id [2];
   logic [31:0]     p_addr [2];
   logic [7:0]      p_len [2];
   logic [2:0]      p_size [2];
   logic [1:0]      p_burst [2];
   int              grant_log[$];
   logic [32:0]     rx0[$], rx1[$], ex0[$], ex1[$];

   // memory-side slave
   typedef struct { logic [31:0] addr; logic [3:0] len; logic [ID_W-1:0] id; } burst_t;
   burst_t bq[$];
   int     ar_delay, ar_wait, beat, rlast_at;
   bit     rgap, r_hold;

   // reference model
   typedef enum {M_IDLE, M_ADDR, M_DATA} mphase_t;
   mphase_t      md_phase;
   logic         md_owner, md_perr;
   logic [1:0]   md_arready;
   int           md_starve, md_left;
   logic [AW-1:0] md_ar;

   logic [AW+8:0] exp_log[$], act_log[$];
   int            n_arvalid_cyc, n_rvalid1;

   function automatic logic [31:0] data_of(input logic [31:0] a, input int i);
      return a ^ (32'(i) * 32'h01010101) ^ 32'hA5A50000;
   endfunction

   task automatic clear_logs();
      exp_log.delete(); act_log.delete(); grant_log.delete();
      rx0.delete(); rx1.delete(); ex0.delete(); ex1.delete();
      n_arvalid_cyc = 0; n_rvalid1 = 0;
   endtask

   task automatic set_req(input int p, input logic [31:0] addr, input logic [7:0] len);
      p_id[p] = ID_W'($urandom); p_addr[p] = addr; p_len[p] = len;
      p_size[p] = 3'd2; p_burst[p] = 2'd1; req[p] = 1'b1;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      req = '0; auto_req = '0; rand_req = 0; rand_rready = 0; stall_cnt = 0;
      for (int p = 0; p < 2; p++) begin
         p_id[p] = '0; p_addr[p] = '0; p_len[p] = '0; p_size[p] = '0; p_burst[p] = '0;
      end
      s_arvalid = '0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
      s_rready = '1;
      bq.delete(); ar_delay = 0; ar_wait = 0; beat = 0; rlast_at = -1; rgap = 0; r_hold = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0;
      m_axi_rid = '0; m_axi_rresp = '0;
      md_phase = M_IDLE; md_owner = 0; md_perr = 0; md_arready = '0; md_starve = 0;
      md_left = 0; md_ar = '0;
      repeat (2) @(posedge aclk);
      #2 aresetn = 1'b1;
   endtask

   // One clock: drive at posedge+2, sample at posedge+3, then advance models.
   task automatic cycle();
      logic [AW+8:0] e, a;
      logic [1:0]    exp_rvalid;
      logic          exp_mrready, w, slv_beat;
      int            last_idx;
      for (int p = 0; p < 2; p++)
         if (!req[p] && (auto_req[p] || (rand_req && $urandom_range(0, 3) == 0)))
            set_req(p, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 15)));
      if (stall_cnt > 0) begin s_rready = '0; stall_cnt--; end
      else if (rand_rready) s_rready = 2'($urandom_range(0, 3));
      else s_rready = '1;
      m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
      if (!r_hold) begin
         if (bq.size() > 0 && (!rgap || $urandom_range(0, 2) != 0)) begin
            last_idx     = (rlast_at >= 0) ? rlast_at : int'(bq[0].len);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = data_of(bq[0].addr, beat);
            m_axi_rlast  = (beat == last_idx);
            m_axi_rid    = bq[0].id;
            m_axi_rresp  = 2'($urandom_range(0, 3));
         end else begin
            m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
         end
      end
      s_arvalid = req;
      s_arid    = {p_id[1], p_id[0]};
      s_araddr  = {p_addr[1], p_addr[0]};
      s_arlen   = {p_len[1], p_len[0]};
      s_arsize  = {p_size[1], p_size[0]};
      s_arburst = {p_burst[1], p_burst[0]};
      #1;
      exp_mrready = (md_phase == M_DATA) ? s_rready[md_owner] : 1'b0;
      exp_rvalid  = (md_phase != M_DATA) ? 2'b00 :
                    (md_owner ? {m_axi_rvalid, 1'b0} : {1'b0, m_axi_rvalid});
      e = {(md_phase == M_ADDR) ? md_ar : AW'(0), md_arready, md_phase != M_IDLE,
           (md_phase != M_IDLE) ? md_owner : 1'b0, exp_rvalid, md_phase == M_ADDR,
           exp_mrready, md_perr};
      a = {m_axi_arvalid ? {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} : AW'(0),
           s_arready, busy, busy ? owner : 1'b0, s_rvalid, m_axi_arvalid, m_axi_rready, protocol_err};
      exp_log.push_back(e); act_log.push_back(a);
      if (m_axi_arvalid) n_arvalid_cyc++;
      if (s_rvalid[1]) n_rvalid1++;
      if (s_rvalid[0] && s_rready[0]) rx0.push_back({s_rlast, s_rdata});
      if (s_rvalid[1] && s_rready[1]) rx1.push_back({s_rlast, s_rdata});
      slv_beat = m_axi_rvalid && m_axi_rready;

      md_arready = '0;
      case (md_phase)
         M_IDLE: if (|req) begin
            w = req[1] && (!req[0] || md_starve >= MAX_WAIT);
            md_arready = w ? 2'b10 : 2'b01;
            md_owner = w;
            md_ar = {p_id[w], p_addr[w], p_len[w][3:0], p_size[w], p_burst[w]};
            md_left = int'(p_len[w][3:0]);
            if (p_len[w][7:4] != 4'd0) md_perr = 1'b1;
            if (w) md_starve = 0;
            else if (req[1]) md_starve = (md_starve < 255) ? md_starve + 1 : 255;
            md_phase = M_ADDR;
         end
         M_ADDR: if (m_axi_arready) md_phase = M_DATA;
         default: if (m_axi_rvalid && exp_mrready) begin
            if (md_owner) ex1.push_back({m_axi_rlast, m_axi_rdata});
            else ex0.push_back({m_axi_rlast, m_axi_rdata});
            if (m_axi_rlast) begin
               if (md_left != 0) md_perr = 1'b1;
               md_phase = M_IDLE;
            end else if (md_left == 0) md_perr = 1'b1;
            else md_left--;
         end
      endcase
      if (!req[1]) md_starve = 0;

      for (int p = 0; p < 2; p++)
         if (req[p] && s_arready[p]) begin req[p] = 1'b0; grant_log.push_back(p); end
      if (m_axi_arvalid && m_axi_arready) begin
         bq.push_back('{addr: m_axi_araddr, len: m_axi_arlen, id: m_axi_arid});
         ar_wait = 0;
      end else if (m_axi_arvalid) ar_wait++;
      if (slv_beat) begin
         r_hold = 0;
         if (m_axi_rlast) begin void'(bq.pop_front()); beat = 0; end
         else beat++;
      end else r_hold = m_axi_rvalid;
      @(posedge aclk);
      #2;
   endtask

   task automatic run_idle(input string name, input int budget);
      int n = 0;
      do begin cycle(); n++; end while ((busy || (|req) || bq.size() != 0) && n < budget);
      vectors++;
      if (n >= budget) begin
         miscompares++;
         $display("FAIL %s_timeout: busy=%0b after %0d cycles, want idle", name, busy, n);
      end
      cycle();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vectors++;
      if ({busy, owner, s_arready, s_rvalid, m_axi_arvalid, m_axi_rready, protocol_err} !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 0", {busy, owner, s_arready, s_rvalid, m_axi_arvalid, m_axi_rready, protocol_err});
      end
      vectors++;
      if ({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} !== AW'(0)) begin
         miscompares++;
         $display("FAIL reset_payload: got %h want 0", {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst});
      end
      vectors++;
      if ({m_axi_arlock, m_axi_arcache, m_axi_arprot} !== 9'd0) begin
         miscompares++;
         $display("FAIL const_attrs: got %h want 0", {m_axi_arlock, m_axi_arcache, m_axi_arprot});
      end
      #1;
   endtask

   task automatic test_dbus_single();
      logic [32:0] want;
      clear_logs();
      ar_delay = 2;
      set_req(0, 32'h1FC0_0000, 8'd3);
      run_idle("dbus_single", 100);
      foreach (exp_log[i]) begin
         vectors++;
         if (act_log[i] !== exp_log[i]) begin
            miscompares++;
            $display("FAIL dbus_single_cyc%0d: got %h want %h", i, act_log[i], exp_log[i]);
         end
      end
      vectors++;
      if (n_arvalid_cyc !== 3) begin miscompares++; $display("FAIL arvalid_hold: got %0d want 3", n_arvalid_cyc); end
      vectors++;
      if (n_rvalid1 !== 0) begin miscompares++; $display("FAIL ibus_rvalid_quiet: got %0d want 0", n_rvalid1); end
      vectors++;
      if (rx0.size() !== 4) begin miscompares++; $display("FAIL dbus_beats: got %0d want 4", rx0.size()); end
      else for (int i = 0; i < 4; i++) begin
         want = {i == 3, data_of(32'h1FC0_0000, i)};
         vectors++;
         if (rx0[i] !== want) begin miscompares++; $display("FAIL dbus_beat%0d: got %h want %h", i, rx0[i], want); end
      end
      ar_delay = 0;
   endtask

   task automatic test_both_priority();
      clear_logs();
      set_req(0, 32'h0000_1000, 8'd2);
      set_req(1, 32'h0000_2000, 8'd1);
      run_idle("both_priority", 200);
      vectors++;
      if (grant_log.size() !== 2 || grant_log[0] !== 0 || grant_log[1] !== 1) begin
         miscompares++;
         $display("FAIL both_order: got %p want '{0,1}", grant_log);
      end
      foreach (exp_log[i]) begin
         vectors++;
         if (act_log[i] !== exp_log[i]) begin
            miscompares++;
            $display("FAIL both_priority_cyc%0d: got %h want %h", i, act_log[i], exp_log[i]);
         end
      end
      vectors++;
      if (rx0 != ex0 || rx1 != ex1) begin
         miscompares++;
         $display("FAIL both_data: got %0d/%0d beats want %0d/%0d", rx0.size(), rx1.size(), ex0.size(), ex1.size());
      end
   endtask

   task automatic test_starvation();
      int want[6] = '{0, 0, 1, 0, 0, 1};
      clear_logs();
      auto_req = 2'b11;
      for (int n = 0; n < 400 && grant_log.size() < 6; n++) cycle();
      auto_req = '0;
      run_idle("starvation", 300);
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (i >= grant_log.size() || grant_log[i] !== want[i]) begin
            miscompares++;
            $display("FAIL starve_grant%0d: got %p want %p", i, grant_log, want);
         end
      end
      foreach (exp_log[i]) begin
         vectors++;
         if (act_log[i] !== exp_log[i]) begin
            miscompares++;
            $display("FAIL starvation_cyc%0d: got %h want %h", i, act_log[i], exp_log[i]);
         end
      end
   endtask

   task automatic test_rready_stall();
      logic [32:0] want;
      clear_logs();
      set_req(0, 32'h0000_8000, 8'd7);
      for (int n = 0; n < 100 && rx0.size() < 2; n++) cycle();
      stall_cnt = 3;
      run_idle("rready_stall", 100);
      foreach (exp_log[i]) begin
         vectors++;
         if (act_log[i] !== exp_log[i]) begin
            miscompares++;
            $display("FAIL rready_stall_cyc%0d: got %h want %h", i, act_log[i], exp_log[i]);
         end
      end
      vectors++;
      if (rx0.size() !== 8) begin miscompares++; $display("FAIL stall_beats: got %0d want 8", rx0.size()); end
      else for (int i = 0; i < 8; i++) begin
         want = {i == 7, data_of(32'h0000_8000, i)};
         vectors++;
         if (rx0[i] !== want) begin miscompares++; $display("FAIL stall_beat%0d: got %h want %h", i, rx0[i], want); end
      end
   endtask

   task automatic test_random();
      clear_logs();
      rand_req = 1; rand_rready = 1; rgap = 1; ar_delay = $urandom_range(0, 3);
      repeat (800) cycle();
      rand_req = 0;
      run_idle("random", 300);
      rand_rready = 0; rgap = 0; ar_delay = 0;
      foreach (exp_log[i]) begin
         vectors++;
         if (act_log[i] !== exp_log[i]) begin
            miscompares++;
            $display("FAIL random_cyc%0d: got %h want %h", i, act_log[i], exp_log[i]);
         end
      end
      vectors++;
      if (rx0 != ex0 || rx1 != ex1 || rx0.size() == 0 || rx1.size() == 0) begin
         miscompares++;
         $display("FAIL random_data: got %0d/%0d beats want %0d/%0d", rx0.size(), rx1.size(), ex0.size(), ex1.size());
      end
   endtask

   task automatic test_early_rlast();
      clear_logs();
      rlast_at = 1;
      set_req(0, 32'h0000_3000, 8'd3);
      run_idle("early_rlast", 100);
      rlast_at = -1;
      repeat (3) cycle();
      foreach (exp_log[i]) begin
         vectors++;
         if (act_log[i] !== exp_log[i]) begin
            miscompares++;
            $display("FAIL early_rlast_cyc%0d: got %h want %h", i, act_log[i], exp_log[i]);
         end
      end
      vectors++;
      if ({protocol_err, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL early_rlast_flags: got err=%0b busy=%0b want err=1 busy=0", protocol_err, busy);
      end
      vectors++;
      if (rx0.size() !== 2) begin miscompares++; $display("FAIL early_rlast_beats: got %0d want 2", rx0.size()); end
   endtask

   task automatic test_async_reset();
      clear_logs();
      set_req(0, 32'h0000_4000, 8'd3);
      for (int n = 0; n < 100 && rx0.size() < 1; n++) cycle();
      vectors++;
      if ({protocol_err, busy} !== 2'b11) begin
         miscompares++;
         $display("FAIL pre_reset: got err=%0b busy=%0b want err=1 busy=1", protocol_err, busy);
      end
      m_axi_rvalid = 1'b1;
      #1 aresetn = 1'b0;
      #1;
      vectors++;
      if ({busy, owner, s_arready, s_rvalid, m_axi_arvalid, m_axi_rready, protocol_err} !== 9'd0) begin
         miscompares++;
         $display("FAIL async_reset_ctrl: got %b want 0", {busy, owner, s_arready, s_rvalid, m_axi_arvalid, m_axi_rready, protocol_err});
      end
      vectors++;
      if ({m_axi_arid, m_axi_araddr, m_axi_arlen} !== 40'd0) begin
         miscompares++;
         $display("FAIL async_reset_payload: got %h want 0", {m_axi_arid, m_axi_araddr, m_axi_arlen});
      end
      do_reset();
      clear_logs();
      set_req(1, 32'h0000_5000, 8'd1);
      run_idle("post_reset", 100);
      vectors++;
      if (grant_log.size() !== 1 || grant_log[0] !== 1 || rx1.size() !== 2) begin
         miscompares++;
         $display("FAIL post_reset_grant: got grants %p beats %0d want '{1} beats 2", grant_log, rx1.size());
      end
      foreach (exp_log[i]) begin
         vectors++;
         if (act_log[i] !== exp_log[i]) begin
            miscompares++;
            $display("FAIL post_reset_cyc%0d: got %h want %h", i, act_log[i], exp_log[i]);
         end
      end
   endtask

   task automatic test_arlen_trunc();
      clear_logs();
      set_req(1, 32'h0000_6000, 8'h13);
      run_idle("arlen_trunc", 100);
      vectors++;
      if (rx1.size() !== 4 || protocol_err !== 1'b1) begin
         miscompares++;
         $display("FAIL arlen_trunc: got beats=%0d err=%0b want beats=4 err=1", rx1.size(), protocol_err);
      end
      foreach (exp_log[i]) begin
         vectors++;
         if (act_log[i] !== exp_log[i]) begin
            miscompares++;
            $display("FAIL arlen_trunc_cyc%0d: got %h want %h", i, act_log[i], exp_log[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_dbus_single();
      test_both_priority();
      test_starvation();
      test_rready_stall();
      test_random();
      test_early_rlast();
      test_async_reset();
      test_arlen_trunc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
